pll_reset_sequencer: RTL and testbench

- Control-side counterpart of the ECP5 HDMI/system PLL.
- Drives the PLL RST pin and consumes its asynchronous LOCK output.
- Releases a clean, glitch-free system reset only after lock has been stable, re-arms the PLL on lock timeout or lock loss, and keeps saturating event counters for debug/CSR readout.
- Runs on the PLL input reference clock (25 MHz), never on a PLL output.

---
 rtl/pll_reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for an ECP5 PLL: pulses the PLL RST pin, qualifies the asynchronous LOCK
// output, and releases a registered system reset once lock has been stable. Runs on the reference clock.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 262144,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] lock_lost_count,
  output logic [CNT_W-1:0] timeout_count
);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // One timer serves every state, so it is sized for the longest dwell.
  localparam int MAX_AB    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD    = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int TIMER_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef logic [TIMER_W-1:0] timer_t;

  localparam timer_t RST_LAST     = timer_t'(PLL_RST_CYCLES - 1);
  localparam timer_t TIMEOUT_LAST = timer_t'(LOCK_TIMEOUT - 1);
  localparam timer_t STABLE_LAST  = timer_t'(STABLE_CYCLES - 1);
  localparam timer_t HOLD_LAST    = timer_t'(HOLD_CYCLES - 1);

  state_t                 state_q;
  state_t                 state_d;
  timer_t                 timer_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   lost_evt;
  logic                   timeout_evt;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value,
                                            input logic             inc,
                                            input logic             clr);
    if (clr) return '0;
    if (inc && (value != '1)) return value + CNT_W'(1);
    return value;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    lost_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      S_PLL_RESET: begin
        if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABILIZE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d     = S_PLL_RESET;
          timeout_evt = 1'b1;
        end
      end
      S_STABILIZE: begin
        // A lock glitch here only restarts the wait; the PLL is not re-armed.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d  = S_PLL_RESET;
          lost_evt = 1'b1;
        end else if (timer_q == HOLD_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d  = S_PLL_RESET;
          lost_evt = 1'b1;
        end
      end
      default: state_d = S_PLL_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_PLL_RESET;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + timer_t'(1);
      end
    end
  end

  // Outputs are registered from the next-state decode: they switch on the same edge as
  // state_q but come straight off flops, so sys_reset cannot glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      pll_rst   <= (state_d == S_PLL_RESET);
      sys_reset <= (state_d != S_RUN);
      ready     <= (state_d == S_RUN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_lost_count <= '0;
      timeout_count   <= '0;
    end else begin
      lock_lost_count <= bump(lock_lost_count, lost_evt, clear_counts);
      timeout_count   <= bump(timeout_count, timeout_evt, clear_counts);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed bring-up/timeout/loss/clear/async-reset scenarios
// plus a randomized lock waveform scored against a dwell-time model of the sequencer.
module tb_pll_reset_sequencer;

  localparam int SYNC    = 2;
  localparam int PRST    = 3;
  localparam int LT      = 32;
  localparam int SC      = 8;
  localparam int HC      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          clear_counts = 1'b0;
  logic          pll_rst;
  logic          sys_reset;
  logic          ready;
  logic [2:0]    state;
  logic [CW-1:0] lock_lost_count;
  logic [CW-1:0] timeout_count;

  int checks = 0;
  int errors = 0;

  // Model: phase 0..4, cycles already spent in it, event tallies, and a delay line for LOCK.
  int m_state;
  int m_dwell;
  int m_lost;
  int m_to;
  bit m_dly[$];

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRST), .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .clear_counts(clear_counts),
    .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .state(state),
    .lock_lost_count(lock_lost_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_state = 0;
    m_dwell = 0;
    m_lost  = 0;
    m_to    = 0;
    m_dly.delete();
    repeat (SYNC) m_dly.push_back(1'b0);
  endtask

  // Applies the sequencing rules for one clock edge given the inputs present at that edge.
  task automatic model_edge(input bit lk, input bit clr);
    bit ls;
    int nxt;
    bit lost_ev;
    bit to_ev;
    if (reset) begin
      model_reset();
      return;
    end
    ls = m_dly.pop_front();
    m_dly.push_back(lk);
    nxt = m_state;
    lost_ev = 1'b0;
    to_ev = 1'b0;
    if (m_state == 0) begin
      if (m_dwell + 1 >= PRST) nxt = 1;
    end else if (m_state == 1) begin
      if (ls) nxt = 2;
      else if (m_dwell + 1 >= LT) begin nxt = 0; to_ev = 1'b1; end
    end else if (m_state == 2) begin
      if (!ls) nxt = 1;
      else if (m_dwell + 1 >= SC) nxt = 3;
    end else if (m_state == 3) begin
      if (!ls) begin nxt = 0; lost_ev = 1'b1; end
      else if (m_dwell + 1 >= HC) nxt = 4;
    end else begin
      if (!ls) begin nxt = 0; lost_ev = 1'b1; end
    end
    m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
    m_state = nxt;
    if (clr) m_lost = 0; else if (lost_ev && m_lost < CNT_MAX) m_lost++;
    if (clr) m_to = 0;   else if (to_ev && m_to < CNT_MAX) m_to++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(pll_locked, clear_counts);
    #1;
  endtask

  // Leaves the bench at cycle 0 (first period after release), one time unit past an edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_run(input string tag, input int budget);
    for (int i = 0; i < budget && ready !== 1'b1; i++) step();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_run: ready=%b after %0d cycles, want 1", tag, ready, budget);
    end
  endtask

  task automatic check_bringup(input string tag);
    for (int c = 0; c <= 20; c++) begin
      int es;
      logic [2:0] exp_o;
      if (c > 0) step();
      es = (c < 3) ? 0 : (c == 3) ? 1 : (c < 12) ? 2 : (c < 16) ? 3 : 4;
      exp_o = {es == 0, es != 4, es == 4};
      checks++;
      if (state !== 3'(es)) begin
        errors++;
        $display("FAIL %s state cycle %0d: got %0d want %0d", tag, c, state, es);
      end
      checks++;
      if ({pll_rst, sys_reset, ready} !== exp_o) begin
        errors++;
        $display("FAIL %s outputs cycle %0d: rst/sys/ready got %b want %b", tag, c,
                 {pll_rst, sys_reset, ready}, exp_o);
      end
    end
    checks++;
    if (lock_lost_count !== '0 || timeout_count !== '0) begin
      errors++;
      $display("FAIL %s counts: lost=%0d timeout=%0d want 0/0", tag, lock_lost_count, timeout_count);
    end
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    do_reset();
    checks++;
    if ({state, pll_rst, sys_reset, ready} !== 6'b000_110) begin
      errors++;
      $display("FAIL reset_values: state/rst/sys/ready got %b want 000110",
               {state, pll_rst, sys_reset, ready});
    end
    checks++;
    if (lock_lost_count !== '0 || timeout_count !== '0) begin
      errors++;
      $display("FAIL reset_counts: lost=%0d timeout=%0d want 0/0", lock_lost_count, timeout_count);
    end
  endtask

  task automatic test_bringup();
    pll_locked = 1'b1;
    do_reset();
    check_bringup("bringup");
  endtask

  task automatic test_glitch();
    pll_locked = 1'b1;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      int es;
      if (c > 0) step();
      es = (c < 3) ? 0 : (c == 3) ? 1 : (c < 9) ? 2 : (c == 9) ? 1 :
           (c < 18) ? 2 : (c < 22) ? 3 : 4;
      checks++;
      if (state !== 3'(es) || pll_rst !== (es == 0)) begin
        errors++;
        $display("FAIL glitch cycle %0d: state=%0d pll_rst=%b want state=%0d pll_rst=%b",
                 c, state, pll_rst, es, es == 0);
      end
      if (c == 6) pll_locked = 1'b0;
      if (c == 7) pll_locked = 1'b1;
    end
    checks++;
    if (lock_lost_count !== '0 || timeout_count !== '0) begin
      errors++;
      $display("FAIL glitch_counts: lost=%0d timeout=%0d want 0/0", lock_lost_count, timeout_count);
    end
  endtask

  task automatic test_loss_run();
    wait_run("loss_pre", 40);
    pll_locked = 1'b0;
    step();
    step();
    step();
    checks++;
    if (state !== 3'd0 || sys_reset !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL loss_latency: state=%0d sys_reset=%b ready=%b want 0/1/0", state, sys_reset, ready);
    end
    checks++;
    if (lock_lost_count !== 4'd1) begin
      errors++;
      $display("FAIL loss_count: got %0d want 1", lock_lost_count);
    end
    pll_locked = 1'b1;
    for (int c = 4; c <= 19; c++) begin
      step();
      if (c == 18) begin
        checks++;
        if (state !== 3'd3) begin
          errors++;
          $display("FAIL relock_hold: state=%0d want 3", state);
        end
      end
    end
    checks++;
    if (state !== 3'd4 || ready !== 1'b1 || sys_reset !== 1'b0) begin
      errors++;
      $display("FAIL relock_run: state=%0d ready=%b sys_reset=%b want 4/1/0", state, ready, sys_reset);
    end
  endtask

  task automatic test_clear_collision();
    wait_run("clear_pre", 40);
    pll_locked = 1'b0;
    step();
    step();
    checks++;
    if (lock_lost_count !== 4'd1) begin
      errors++;
      $display("FAIL clear_precount: got %0d want 1", lock_lost_count);
    end
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    checks++;
    if (lock_lost_count !== 4'd0 || state !== 3'd0) begin
      errors++;
      $display("FAIL clear_wins: lost=%0d state=%0d want 0/0", lock_lost_count, state);
    end
    pll_locked = 1'b1;
    wait_run("clear_post", 40);
  endtask

  task automatic test_never_lock();
    pll_locked = 1'b0;
    do_reset();
    for (int c = 0; c <= 38; c++) begin
      int es;
      if (c > 0) step();
      es = (c < 3) ? 0 : (c < 35) ? 1 : (c < 38) ? 0 : 1;
      checks++;
      if (state !== 3'(es) || pll_rst !== (es == 0)) begin
        errors++;
        $display("FAIL timeout cycle %0d: state=%0d pll_rst=%b want %0d/%b", c, state, pll_rst, es, es == 0);
      end
      if (c == 34 || c == 35) begin
        checks++;
        if (timeout_count !== 4'(c - 34)) begin
          errors++;
          $display("FAIL timeout_count cycle %0d: got %0d want %0d", c, timeout_count, c - 34);
        end
      end
    end
    for (int c = 39; c <= 700; c++) begin
      step();
      if (c == 525 || c == 700) begin
        checks++;
        if (timeout_count !== 4'd15) begin
          errors++;
          $display("FAIL timeout_saturate cycle %0d: got %0d want 15", c, timeout_count);
        end
      end
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL timeout_20th: state=%0d want 0", state);
    end
  endtask

  task automatic test_async_reset();
    pll_locked = 1'b1;
    wait_run("async_pre", 60);
    checks++;
    if (timeout_count !== 4'd15) begin
      errors++;
      $display("FAIL async_precount: got %0d want 15", timeout_count);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({state, pll_rst, sys_reset, ready} !== 6'b000_110 ||
        lock_lost_count !== '0 || timeout_count !== '0) begin
      errors++;
      $display("FAIL async_immediate: state/rst/sys/ready=%b lost=%0d timeout=%0d want 000110 0 0",
               {state, pll_rst, sys_reset, ready}, lock_lost_count, timeout_count);
    end
    step();
    step();
    reset = 1'b0;
    model_reset();
    check_bringup("async");
  endtask

  task automatic test_random();
    int span = 0;
    pll_locked = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (span == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        span = $urandom_range(1, 50);
      end
      span--;
      clear_counts = ($urandom_range(0, 63) == 0);
      step();
      checks++;
      if (state !== 3'(m_state) || pll_rst !== (m_state == 0) ||
          sys_reset !== (m_state != 4) || ready !== (m_state == 4)) begin
        errors++;
        $display("FAIL random cycle %0d: state=%0d rst/sys/ready=%b want state=%0d", c, state,
                 {pll_rst, sys_reset, ready}, m_state);
      end
      checks++;
      if (lock_lost_count !== CW'(m_lost) || timeout_count !== CW'(m_to)) begin
        errors++;
        $display("FAIL random_counts cycle %0d: lost=%0d timeout=%0d want %0d/%0d", c,
                 lock_lost_count, timeout_count, m_lost, m_to);
      end
    end
    clear_counts = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bringup();
    test_glitch();
    test_loss_run();
    test_clear_collision();
    test_never_lock();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
